accel_job_master: RTL and testbench

Wishbone classic master that runs one complete job on the memory-mapped AI accelerator slave. Per job it streams operand words into the accelerator SRAM window, writes the operation register, writes the start code 0xFFFF_FFFF to the status register, and polls status until it reads 0. It then reads the result words back onto an output stream. It sits between a host or sequencer core and the accelerator's Wishbone slave port.

---
 rtl/accel_job_master.sv | 234 +++++++++++++++++++++++
 tb/tb_accel_job_master.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_job_master.sv
// Wishbone classic master that runs one job on the AI accelerator slave:
// load operands, write op and start code, poll status, stream results out.
module accel_job_master #(
    parameter logic [31:0] ADDR_OFFSET = 32'h3000_0000,
    parameter int unsigned DATA_BASE   = 8,
    parameter int unsigned POLL_GAP    = 16,
    parameter int unsigned MAX_POLLS   = 1024,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    input  logic [31:0] op_i,
    input  logic [7:0]  load_words_i,
    input  logic [7:0]  res_base_i,
    input  logic [7:0]  res_words_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_o,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LAST = 16'(MAX_POLLS - 1);
    localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);
    localparam logic [31:0] STAT_ADR  = ADDR_OFFSET + 32'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_WAIT, S_LOAD_WR, S_OP_WR, S_GO_WR,
        S_POLL_GAP, S_POLL_RD, S_RES_RD, S_RES_OUT, S_FINISH
    } state_t;

    state_t      state;
    logic [31:0] op_q;
    logic [31:0] operand_q;
    logic [7:0]  load_words_q;
    logic [7:0]  res_base_q;
    logic [7:0]  res_words_q;
    logic [7:0]  idx_q;
    logic [15:0] gap_cnt_q;
    logic [15:0] poll_cnt_q;
    logic [15:0] ack_cnt_q;

    logic        bus_state;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [7:0]  word_idx;
    logic        ack_ok;

    assign ack_ok   = wbm_stb_o && wbm_ack_i;
    assign word_idx = (state == S_RES_RD) ? 8'(res_base_q + idx_q) : idx_q;

    always_comb begin
        bus_state = 1'b1;
        req_we    = 1'b0;
        req_adr   = '0;
        req_dat   = '0;
        unique case (state)
            S_LOAD_WR: begin
                req_we  = 1'b1;
                req_adr = ADDR_OFFSET + 32'(DATA_BASE) + {22'b0, word_idx, 2'b00};
                req_dat = operand_q;
            end
            S_OP_WR: begin
                req_we  = 1'b1;
                req_adr = ADDR_OFFSET;
                req_dat = op_q;
            end
            S_GO_WR: begin
                req_we  = 1'b1;
                req_adr = STAT_ADR;
                req_dat = '1;
            end
            S_POLL_RD: req_adr = STAT_ADR;
            S_RES_RD:  req_adr = ADDR_OFFSET + 32'(DATA_BASE) + {22'b0, word_idx, 2'b00};
            default:   bus_state = 1'b0;
        endcase
    end

    // Each bus state spends its first cycle with stb low and launches from
    // there, which guarantees the idle cycle between back-to-back transfers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= S_IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= '0;
            in_ready_o   <= 1'b0;
            out_valid_o  <= 1'b0;
            out_data_o   <= '0;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_we_o     <= 1'b0;
            wbm_sel_o    <= '0;
            wbm_adr_o    <= '0;
            wbm_dat_o    <= '0;
            op_q         <= '0;
            operand_q    <= '0;
            load_words_q <= '0;
            res_base_q   <= '0;
            res_words_q  <= '0;
            idx_q        <= '0;
            gap_cnt_q    <= '0;
            poll_cnt_q   <= '0;
            ack_cnt_q    <= '0;
        end else begin
            done_o <= 1'b0;

            if (ack_ok) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                wbm_sel_o <= '0;
            end else if (wbm_stb_o) begin
                if (ack_cnt_q == ACK_LAST) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                    wbm_sel_o <= '0;
                    err_o     <= 2'b01;
                    state     <= S_FINISH;
                    done_o    <= 1'b1;
                    busy_o    <= 1'b0;
                end else begin
                    ack_cnt_q <= ack_cnt_q + 16'd1;
                end
            end else if (bus_state) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_sel_o <= 4'hF;
                wbm_we_o  <= req_we;
                wbm_adr_o <= req_adr;
                wbm_dat_o <= req_dat;
                ack_cnt_q <= '0;
            end

            unique case (state)
                S_IDLE: if (start_i) begin
                    op_q         <= op_i;
                    load_words_q <= load_words_i;
                    res_base_q   <= res_base_i;
                    res_words_q  <= res_words_i;
                    idx_q        <= '0;
                    err_o        <= '0;
                    busy_o       <= 1'b1;
                    if (load_words_i == 8'd0) begin
                        state <= S_OP_WR;
                    end else begin
                        state      <= S_LOAD_WAIT;
                        in_ready_o <= 1'b1;
                    end
                end
                S_LOAD_WAIT: if (in_valid_i) begin
                    operand_q  <= in_data_i;
                    in_ready_o <= 1'b0;
                    state      <= S_LOAD_WR;
                end
                S_LOAD_WR: if (ack_ok) begin
                    if (8'(idx_q + 8'd1) == load_words_q) begin
                        idx_q <= '0;
                        state <= S_OP_WR;
                    end else begin
                        idx_q      <= idx_q + 8'd1;
                        in_ready_o <= 1'b1;
                        state      <= S_LOAD_WAIT;
                    end
                end
                S_OP_WR: if (ack_ok) state <= S_GO_WR;
                S_GO_WR: if (ack_ok) begin
                    gap_cnt_q  <= '0;
                    poll_cnt_q <= '0;
                    state      <= S_POLL_GAP;
                end
                S_POLL_GAP: begin
                    if (gap_cnt_q == GAP_LAST) state <= S_POLL_RD;
                    else gap_cnt_q <= gap_cnt_q + 16'd1;
                end
                S_POLL_RD: if (ack_ok) begin
                    if (wbm_dat_i == '0) begin
                        if (res_words_q == 8'd0) begin
                            state  <= S_FINISH;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            state <= S_RES_RD;
                        end
                    end else if (poll_cnt_q == POLL_LAST) begin
                        err_o  <= 2'b10;
                        state  <= S_FINISH;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end else begin
                        poll_cnt_q <= poll_cnt_q + 16'd1;
                        gap_cnt_q  <= '0;
                        state      <= S_POLL_GAP;
                    end
                end
                S_RES_RD: if (ack_ok) begin
                    out_data_o  <= wbm_dat_i;
                    out_valid_o <= 1'b1;
                    state       <= S_RES_OUT;
                end
                S_RES_OUT: if (out_ready_i) begin
                    out_valid_o <= 1'b0;
                    if (8'(idx_q + 8'd1) == res_words_q) begin
                        state  <= S_FINISH;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 8'd1;
                        state <= S_RES_RD;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_job_master.sv
// Directed bench for accel_job_master: 1-wait-state Wishbone slave model,
// operand source and result sink with optional gaps/stalls.
module tb_accel_job_master;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int unsigned PGAP = 4;
    localparam int unsigned MAXP = 4;
    localparam int unsigned ATO  = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic [31:0] op;
    logic [7:0]  load_words, res_base, res_words;
    logic        busy, done;
    logic [1:0]  err;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack;

    always #5 clk = ~clk;

    accel_job_master #(
        .ADDR_OFFSET(BASE),
        .DATA_BASE(8),
        .POLL_GAP(PGAP),
        .MAX_POLLS(MAXP),
        .ACK_TIMEOUT(ATO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .start_i(start), .op_i(op), .load_words_i(load_words),
        .res_base_i(res_base), .res_words_i(res_words),
        .busy_o(busy), .done_o(done), .err_o(err),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] stamp;
    } tx_t;

    tx_t         txq[$];
    logic [31:0] rxq[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] cyc_n = '0;
    always @(posedge clk) cyc_n = cyc_n + 32'd1;

    // Slave: ack one cycle after stb is seen; status returns 0 from read
    // number zero_at on (0 = never), result words return adr ^ 5A5A_0000.
    logic armed = 1'b0;
    logic block_op = 1'b0, block_res = 1'b0;
    int   zero_at = 0, status_reads = 0;
    always @(negedge clk) begin
        if (stb && !ack && !(block_op && we && adr == BASE)
            && !(block_res && !we && adr >= BASE + 32'd8)) begin
            if (armed) begin
                ack = 1'b1;
                if (!we) begin
                    if (adr == BASE + 32'd4) begin
                        status_reads++;
                        dat_i = (zero_at != 0 && status_reads >= zero_at) ? 32'h0 : 32'h1;
                    end else begin
                        dat_i = adr ^ 32'h5A5A_0000;
                    end
                end
                txq.push_back('{we, adr, dat_o, cyc_n});
            end else begin
                armed = 1'b1;
            end
        end else begin
            ack   = 1'b0;
            armed = 1'b0;
        end
    end

    // Bus protocol monitor: stable request while stb high, clean idle otherwise.
    int          run = 0, last_run = 0, max_run = 0, proto_err = 0;
    logic [68:0] last_bus = '0;
    always @(negedge clk) begin
        if (stb) begin
            if (run > 0 && {we, adr, dat_o, sel} !== last_bus) proto_err++;
            if (!cyc || sel !== 4'hF) proto_err++;
            last_bus = {we, adr, dat_o, sel};
            run++;
        end else begin
            if (run > 0) begin
                last_run = run;
                if (run > max_run) max_run = run;
            end
            run = 0;
            if (cyc || we || sel != 4'h0) proto_err++;
        end
    end

    // Operand source with optional every-other-cycle gaps.
    logic [31:0] ops[8];
    int   op_n = 0, op_pos = 0;
    logic gap_mode = 1'b0, tog = 1'b0, rdy_seen = 1'b0;
    always @(negedge clk) begin
        if (in_valid && rdy_seen) op_pos++;
        tog = ~tog;
        if (op_pos < op_n && !(gap_mode && tog)) begin
            in_valid = 1'b1;
            in_data  = ops[op_pos];
        end else begin
            in_valid = 1'b0;
        end
        rdy_seen = in_ready;
    end

    // Result sink: optionally stalls the first stall_left valid cycles.
    int          stall_left = 0, stall_cnt = 0, stall_err = 0;
    logic [31:0] held = '0;
    always @(negedge clk) begin
        if (out_valid) begin
            if (stall_left > 0) begin
                if (stall_cnt == 0) held = out_data;
                else if (out_data !== held) stall_err++;
                if (cyc) stall_err++;
                stall_cnt++;
                stall_left--;
                out_ready = 1'b0;
            end else begin
                out_ready = 1'b1;
                rxq.push_back(out_data);
            end
        end else begin
            out_ready = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tx_w(input int k, input logic [31:0] a, input logic [31:0] d);
        if (k < txq.size()) begin
            chk("wr_adr", {31'b0, txq[k].we, txq[k].adr}, {31'b0, 1'b1, a});
            chk("wr_dat", {32'b0, txq[k].dat}, {32'b0, d});
        end else begin
            chk("wr_missing", 64'(txq.size()), 64'(k + 1));
        end
    endtask

    task automatic tx_r(input int k, input logic [31:0] a);
        if (k < txq.size()) chk("rd_adr", {31'b0, txq[k].we, txq[k].adr}, {31'b0, 1'b0, a});
        else chk("rd_missing", 64'(txq.size()), 64'(k + 1));
    endtask

    task automatic clear_logs();
        txq.delete();
        rxq.delete();
        status_reads = 0;
        max_run      = 0;
        last_run     = 0;
        stall_cnt    = 0;
        stall_err    = 0;
        op_pos       = 0;
    endtask

    task automatic start_job(input logic [31:0] o, input logic [7:0] lw, input logic [7:0] rb,
                             input logic [7:0] rw);
        @(posedge clk); #1;
        op = o; load_words = lw; res_base = rb; res_words = rw; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {63'b0, busy}, 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", {63'b0, done}, 64'd1);
        chk("busy_at_done", {63'b0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", {63'b0, done}, 64'd0);
    endtask

    initial begin
        start = 1'b0; op = '0; load_words = '0; res_base = '0; res_words = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; dat_i = '0; ack = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {54'b0, busy, done, err, cyc, stb, we, sel, in_ready, out_valid}, 64'd0);
        chk("rst_adr_dat", {adr, dat_o}, 64'd0);
        chk("rst_out_data", {32'b0, out_data}, 64'd0);
        #3 rst_n = 1'b1;

        // Job 1: three operands, status zero on the 2nd poll, one result.
        clear_logs();
        ops[0] = 32'h1111_AAAA; ops[1] = 32'h2222_BBBB; ops[2] = 32'h3333_CCCC; op_n = 3;
        zero_at = 2;
        start_job(32'd1, 8'd3, 8'd3, 8'd1);
        wait_done();
        chk("j1_tx_count", 64'(txq.size()), 64'd8);
        tx_w(0, 32'h3000_0008, 32'h1111_AAAA);
        tx_w(1, 32'h3000_000C, 32'h2222_BBBB);
        tx_w(2, 32'h3000_0010, 32'h3333_CCCC);
        tx_w(3, 32'h3000_0000, 32'h0000_0001);
        tx_w(4, 32'h3000_0004, 32'hFFFF_FFFF);
        tx_r(5, 32'h3000_0004);
        tx_r(6, 32'h3000_0004);
        tx_r(7, 32'h3000_0014);
        chk("j1_rx_count", 64'(rxq.size()), 64'd1);
        if (rxq.size() > 0) chk("j1_rx0", {32'b0, rxq[0]}, {32'b0, 32'h6A5A_0014});
        chk("j1_err", {62'b0, err}, 64'd0);
        chk("j1_stb_len", 64'(max_run), 64'd2);

        // Job 2: no operands, no results; done after first zero status.
        clear_logs();
        op_n = 0; zero_at = 1;
        start_job(32'd2, 8'd0, 8'd0, 8'd0);
        wait_done();
        chk("j2_tx_count", 64'(txq.size()), 64'd3);
        tx_w(0, 32'h3000_0000, 32'h0000_0002);
        tx_w(1, 32'h3000_0004, 32'hFFFF_FFFF);
        tx_r(2, 32'h3000_0004);
        chk("j2_rx_count", 64'(rxq.size()), 64'd0);
        chk("j2_err", {62'b0, err}, 64'd0);

        // Job 3: status never clears -> poll timeout after MAXP reads.
        clear_logs();
        zero_at = 0;
        start_job(32'd1, 8'd0, 8'd0, 8'd1);
        wait_done();
        chk("j3_status_reads", 64'(status_reads), 64'(MAXP));
        chk("j3_tx_count", 64'(txq.size()), 64'(MAXP + 2));
        for (int k = 3; k < txq.size(); k++)
            chk("j3_poll_spacing", {63'b0, (txq[k].stamp - txq[k-1].stamp) >= 32'(PGAP + 2)}, 64'd1);
        chk("j3_err", {62'b0, err}, 64'd2);
        chk("j3_rx_count", 64'(rxq.size()), 64'd0);

        // Job 4: op write never acked -> ack timeout.
        clear_logs();
        block_op = 1'b1; zero_at = 1;
        start_job(32'd1, 8'd0, 8'd0, 8'd1);
        wait_done();
        chk("j4_err", {62'b0, err}, 64'd1);
        chk("j4_stb_len", 64'(last_run), 64'(ATO));
        chk("j4_tx_count", 64'(txq.size()), 64'd0);
        chk("j4_cyc_low", {62'b0, cyc, stb}, 64'd0);
        block_op = 1'b0;

        // Job 5: gapped operands, stalled result sink, result index wraps 255 -> 0.
        clear_logs();
        ops[0] = 32'hDDDD_0001; ops[1] = 32'hEEEE_0002; op_n = 2;
        gap_mode = 1'b1; stall_left = 10; zero_at = 1;
        start_job(32'd2, 8'd2, 8'hFF, 8'd2);
        wait_done();
        gap_mode = 1'b0;
        chk("j5_tx_count", 64'(txq.size()), 64'd7);
        tx_w(0, 32'h3000_0008, 32'hDDDD_0001);
        tx_w(1, 32'h3000_000C, 32'hEEEE_0002);
        tx_r(5, 32'h3000_0404);
        tx_r(6, 32'h3000_0008);
        chk("j5_rx_count", 64'(rxq.size()), 64'd2);
        if (rxq.size() > 1) begin
            chk("j5_rx0", {32'b0, rxq[0]}, {32'b0, 32'h6A5A_0404});
            chk("j5_rx1", {32'b0, rxq[1]}, {32'b0, 32'h6A5A_0008});
        end
        chk("j5_stall_cycles", 64'(stall_cnt), 64'd10);
        chk("j5_stall_stable", 64'(stall_err), 64'd0);

        // Job 6: reset asserted while a result read is outstanding.
        clear_logs();
        block_res = 1'b1; op_n = 0; zero_at = 1;
        start_job(32'd1, 8'd0, 8'd3, 8'd1);
        begin
            int n;
            n = 0;
            while (!(stb === 1'b1 && we === 1'b0 && adr === 32'h3000_0014) && n < 500) begin
                @(posedge clk); #1;
                n++;
            end
            chk("j6_res_rd_seen", {63'b0, n < 500}, 64'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("j6_rst_bus", {62'b0, cyc, stb}, 64'd0);
        chk("j6_rst_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        block_res = 1'b0;

        clear_logs();
        ops[0] = 32'hF00D_CAFE; op_n = 1; zero_at = 1;
        start_job(32'd1, 8'd1, 8'd3, 8'd1);
        wait_done();
        chk("j6_tx_count", 64'(txq.size()), 64'd5);
        tx_w(0, 32'h3000_0008, 32'hF00D_CAFE);
        tx_w(1, 32'h3000_0000, 32'h0000_0001);
        tx_r(4, 32'h3000_0014);
        chk("j6_rx_count", 64'(rxq.size()), 64'd1);
        if (rxq.size() > 0) chk("j6_rx0", {32'b0, rxq[0]}, {32'b0, 32'h6A5A_0014});
        chk("j6_err", {62'b0, err}, 64'd0);

        chk("protocol", 64'(proto_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
